// File: rtl/decode_stage_if.sv
// Fetch/register-file/execute-facing signal bundle for the RV32I decode stage.
// slave = decode stage side, master = controller/fetch/regfile/execute side.
interface decode_stage_if;
  logic        enabled;
  logic        completed;
  logic [31:0] pc;
  logic [31:0] instr_raw;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [3:0]  iclass;
  logic        illegal;

  modport slave (
    input  enabled, pc, instr_raw, rs1_rdata, rs2_rdata,
    output completed, rs1_addr, rs2_addr, pc_out, instr_out, rd, funct3,
           funct7_5, rs1_val, rs2_val, imm, iclass, illegal
  );

  modport master (
    output enabled, pc, instr_raw, rs1_rdata, rs2_rdata,
    input  completed, rs1_addr, rs2_addr, pc_out, instr_out, rd, funct3,
           funct7_5, rs1_val, rs2_val, imm, iclass, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: IDLE -> READ -> DONE, registered decode results, one-cycle completed pulse.
// Optional macro RV32M_EN: OP with funct7=0x01 decodes as MULDIV (class 11) instead of illegal.
module decode_stage #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rstn,
    decode_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

    localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3,
                           C_BRANCH = 4'd4, C_LOAD = 4'd5, C_STORE = 4'd6, C_OPIMM = 4'd7,
                           C_OP = 4'd8, C_MISCMEM = 4'd9, C_SYSTEM = 4'd10, C_MULDIV = 4'd11,
                           C_ILL = 4'd15;

    state_e state_q;

    logic [XLEN-1:0] ins;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_d;
    logic [3:0]      cls_d;
    logic            bad;

    assign ins = bus.instr_out;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    // Decode always works on the latched instruction so it is stable during READ.
    always_comb begin
        imm_d = '0;
        cls_d = C_ILL;
        bad   = 1'b0;
        case (opc)
            7'b0110111: begin cls_d = C_LUI;   imm_d = {ins[31:12], 12'b0}; end
            7'b0010111: begin cls_d = C_AUIPC; imm_d = {ins[31:12], 12'b0}; end
            7'b1101111: begin
                cls_d = C_JAL;
                imm_d = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin
                cls_d = C_JALR;
                imm_d = {{20{ins[31]}}, ins[31:20]};
                bad   = (f3 != 3'd0);
            end
            7'b1100011: begin
                cls_d = C_BRANCH;
                imm_d = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                bad   = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'b0000011: begin
                cls_d = C_LOAD;
                imm_d = {{20{ins[31]}}, ins[31:20]};
                bad   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            7'b0100011: begin
                cls_d = C_STORE;
                imm_d = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                bad   = (f3 > 3'd2);
            end
            7'b0010011: begin
                cls_d = C_OPIMM;
                imm_d = {{20{ins[31]}}, ins[31:20]};
                if (f3 == 3'd1)      bad = (f7 != 7'h00);
                else if (f3 == 3'd5) bad = (f7 != 7'h00) && (f7 != 7'h20);
            end
            7'b0110011: begin
                cls_d = C_OP;
                if (f7 == 7'h20)      bad = (f3 != 3'd0) && (f3 != 3'd5);
                else if (f7 == 7'h01) begin
`ifdef RV32M_EN
                    cls_d = C_MULDIV;
`else
                    bad   = 1'b1;
`endif
                end
                else if (f7 != 7'h00) bad = 1'b1;
            end
            7'b0001111: cls_d = C_MISCMEM;
            7'b1110011: begin cls_d = C_SYSTEM; imm_d = {{20{ins[31]}}, ins[31:20]}; end
            default:    cls_d = C_ILL;
        endcase
        if (bad) cls_d = C_ILL;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            bus.completed <= 1'b0;
            bus.rs1_addr  <= '0;
            bus.rs2_addr  <= '0;
            bus.pc_out    <= '0;
            bus.instr_out <= '0;
            bus.rd        <= '0;
            bus.funct3    <= '0;
            bus.funct7_5  <= 1'b0;
            bus.rs1_val   <= '0;
            bus.rs2_val   <= '0;
            bus.imm       <= '0;
            bus.iclass    <= '0;
            bus.illegal   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus.completed <= 1'b0;
                    if (bus.enabled) begin
                        bus.instr_out <= bus.instr_raw;
                        bus.pc_out    <= bus.pc;
                        bus.rs1_addr  <= bus.instr_raw[19:15];
                        bus.rs2_addr  <= bus.instr_raw[24:20];
                        state_q       <= READ;
                    end
                end
                READ: begin
                    // x0 reads as zero whatever the register file returns.
                    bus.rs1_val   <= (bus.rs1_addr == 5'd0) ? '0 : bus.rs1_rdata;
                    bus.rs2_val   <= (bus.rs2_addr == 5'd0) ? '0 : bus.rs2_rdata;
                    bus.rd        <= ins[11:7];
                    bus.funct3    <= f3;
                    bus.funct7_5  <= ins[30];
                    bus.imm       <= imm_d;
                    bus.iclass    <= cls_d;
                    bus.illegal   <= (cls_d == C_ILL);
                    bus.completed <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    bus.completed <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    bus.completed <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, multi-cycle sequences,
// and random instructions against a field-rule reference model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    decode_stage_if bus ();
    decode_stage #(.XLEN(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f75;
        logic [31:0] imm;
        logic [3:0]  cls;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  cls;
        logic [31:0] imm;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: imm built by arithmetic on the sign-shifted word, class from opcode rules.
    function automatic exp_t model(input logic [31:0] i);
        exp_t        e;
        logic [31:0] sx;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        ok;
        sx = $unsigned($signed(i) >>> 20);
        op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
        e.rd = i[11:7]; e.f3 = f3; e.f75 = i[30]; e.imm = 32'd0; e.cls = 4'd15;
        ok = 1'b1;
        if (op == 7'h37)      begin e.cls = 0; e.imm = i & 32'hFFFFF000; end
        else if (op == 7'h17) begin e.cls = 1; e.imm = i & 32'hFFFFF000; end
        else if (op == 7'h6F) begin
            e.cls = 2;
            e.imm = (sx & 32'hFFF007FE) | (i & 32'h000FF000) | (32'(i[20]) << 11);
        end
        else if (op == 7'h67) begin e.cls = 3; e.imm = sx; ok = (f3 == 0); end
        else if (op == 7'h63) begin
            e.cls = 4;
            e.imm = (sx & 32'hFFFFF7E0) | (32'(i[7]) << 11) | (32'(i[11:8]) << 1);
            ok = !(f3 inside {3'd2, 3'd3});
        end
        else if (op == 7'h03) begin e.cls = 5; e.imm = sx; ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; end
        else if (op == 7'h23) begin e.cls = 6; e.imm = (sx & 32'hFFFFFFE0) | 32'(i[11:7]); ok = (f3 <= 2); end
        else if (op == 7'h13) begin
            e.cls = 7; e.imm = sx;
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
        end
        else if (op == 7'h33) begin
            e.cls = 8;
            if (f7 == 7'h20) ok = f3 inside {3'd0, 3'd5};
            else if (f7 == 7'h01) begin
`ifdef RV32M_EN
                e.cls = 11;
`else
                ok = 1'b0;
`endif
            end
            else ok = (f7 == 0);
        end
        else if (op == 7'h0F) e.cls = 9;
        else if (op == 7'h73) begin e.cls = 10; e.imm = sx; end
        if (!ok) e.cls = 15;
        return e;
    endfunction

    task automatic run_one(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e = model(instr);
        @(negedge clk);
        bus.enabled = 1'b1; bus.instr_raw = instr; bus.pc = pc;
        bus.rs1_rdata = r1; bus.rs2_rdata = r2;
        @(posedge clk); #1;
        bus.enabled = 1'b0; bus.instr_raw = $urandom; bus.pc = $urandom;
        chk("start_completed", 32'(bus.completed), 32'd0);
        chk("rs1_addr", 32'(bus.rs1_addr), 32'(instr[19:15]));
        chk("rs2_addr", 32'(bus.rs2_addr), 32'(instr[24:20]));
        chk("pc_out", bus.pc_out, pc);
        chk("instr_out", bus.instr_out, instr);
        @(posedge clk); #1;
        chk("completed_pulse", 32'(bus.completed), 32'd1);
        chk("rd", 32'(bus.rd), 32'(e.rd));
        chk("funct3", 32'(bus.funct3), 32'(e.f3));
        chk("funct7_5", 32'(bus.funct7_5), 32'(e.f75));
        chk("rs1_val", bus.rs1_val, (instr[19:15] == 0) ? 32'd0 : r1);
        chk("rs2_val", bus.rs2_val, (instr[24:20] == 0) ? 32'd0 : r2);
        chk("imm", bus.imm, e.imm);
        chk("iclass", 32'(bus.iclass), 32'(e.cls));
        chk("illegal", 32'(bus.illegal), 32'(e.cls == 4'd15));
        @(posedge clk); #1;
        chk("completed_drop", 32'(bus.completed), 32'd0);
    endtask

    vec_t vecs[$];
    logic [6:0] ops[12];
    logic [31:0] ri, saved_imm;
    int pulses;
    logic samp[8];

    initial begin
        bus.enabled = 1'b0; bus.pc = '0; bus.instr_raw = '0;
        bus.rs1_rdata = '0; bus.rs2_rdata = '0;
        #2;
        chk("rst_completed", 32'(bus.completed), 32'd0);
        chk("rst_outs", bus.pc_out | bus.instr_out | bus.imm | bus.rs1_val | bus.rs2_val, 32'd0);
        chk("rst_fields", {bus.rs1_addr, bus.rs2_addr, bus.rd, bus.funct3, bus.funct7_5, bus.iclass, bus.illegal}, 32'd0);
        @(negedge clk); rstn = 1'b1;

        vecs.push_back('{32'hFFF00293, 32'h100, 32'hDEAD, 32'h0,  4'd7,  32'hFFFFFFFF}); // addi x5,x0,-1
        vecs.push_back('{32'h0020A423, 32'h104, 32'h1000, 32'hAB, 4'd6,  32'h8});        // sw x2,8(x1)
        vecs.push_back('{32'hFE208EE3, 32'h108, 32'h1,    32'h2,  4'd4,  32'hFFFFFFFC}); // beq -4
`ifdef RV32M_EN
        vecs.push_back('{32'h022081B3, 32'h10C, 32'h5,    32'h6,  4'd11, 32'h0});        // mul
`else
        vecs.push_back('{32'h022081B3, 32'h10C, 32'h5,    32'h6,  4'd15, 32'h0});
`endif
        vecs.push_back('{32'h00000000, 32'h110, 32'h7,    32'h8,  4'd15, 32'h0});
        vecs.push_back('{32'h123452B7, 32'h114, 32'h0,    32'h0,  4'd0,  32'h12345000}); // lui
        vecs.push_back('{32'h008000EF, 32'h118, 32'h0,    32'h0,  4'd2,  32'h8});        // jal +8
        vecs.push_back('{32'h00013083, 32'h11C, 32'h3,    32'h0,  4'd15, 32'h0});        // load f3=3
        vecs.push_back('{32'h402081B3, 32'h120, 32'h9,    32'hA,  4'd8,  32'h0});        // sub
        vecs.push_back('{32'h402091B3, 32'h124, 32'h9,    32'hA,  4'd15, 32'h0});        // f7=0x20,f3=1
        vecs.push_back('{32'h40315093, 32'h128, 32'h9,    32'h0,  4'd7,  32'h403});      // srai
        vecs.push_back('{32'h40311093, 32'h12C, 32'h9,    32'h0,  4'd15, 32'h403});      // slli bad f7
        vecs.push_back('{32'h000090E7, 32'h130, 32'h9,    32'h0,  4'd15, 32'h0});        // jalr f3=1
        vecs.push_back('{32'h00000073, 32'h134, 32'h0,    32'h0,  4'd10, 32'h0});        // ecall
        vecs.push_back('{32'h0FF0000F, 32'h138, 32'h0,    32'h0,  4'd9,  32'h0});        // fence

        foreach (vecs[k]) begin
            run_one(vecs[k].instr, vecs[k].pc, vecs[k].r1, vecs[k].r2);
            chk("vec_iclass", 32'(bus.iclass), 32'(vecs[k].cls));
            chk("vec_imm", bus.imm, vecs[k].imm);
            chk("vec_illegal", 32'(bus.illegal), 32'(vecs[k].cls == 4'd15));
        end

        // Outputs hold across idle cycles.
        saved_imm = bus.imm;
        repeat (3) @(posedge clk);
        #1 chk("hold_imm", bus.imm, saved_imm);
        chk("hold_instr", bus.instr_out, 32'h0FF0000F);

        // Reset during READ: immediate clear, no pulse, then normal restart.
        @(negedge clk);
        bus.enabled = 1'b1; bus.instr_raw = 32'h0020A423; bus.pc = 32'h200;
        @(posedge clk); #1 bus.enabled = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("abort_outs", bus.pc_out | bus.instr_out | bus.imm, 32'd0);
        chk("abort_fields", {bus.rs1_addr, bus.rs2_addr, bus.rd, bus.funct3, bus.iclass, bus.completed}, 32'd0);
        pulses = 0;
        repeat (2) begin @(posedge clk); #1 pulses += int'(bus.completed); end
        @(negedge clk); rstn = 1'b1;
        repeat (2) begin @(posedge clk); #1 pulses += int'(bus.completed); end
        chk("abort_no_pulse", 32'(pulses), 32'd0);
        run_one(32'hFFF00293, 32'h100, 32'hDEAD, 32'h0);

        // Enabled held high for 6 edges: pulses seen after edges 1 and 4.
        @(negedge clk);
        bus.enabled = 1'b1; bus.instr_raw = 32'h0020A423; bus.pc = 32'h300;
        bus.rs1_rdata = 32'h1000; bus.rs2_rdata = 32'hAB;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            samp[k] = bus.completed;
            if (k == 5) bus.enabled = 1'b0;
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) pulses += int'(samp[k]);
        chk("held_pulse_count", 32'(pulses), 32'd2);
        chk("held_pulse_pos", {30'd0, samp[1], samp[4]}, 32'd3);

        // Random instructions with biased opcodes and OP funct7.
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
        for (int n = 0; n < 150; n++) begin
            int sel;
            ri  = $urandom;
            sel = int'($urandom_range(0, 11));
            if (sel < 11) ri[6:0] = ops[sel];
            if (ri[6:0] == 7'h33 || ri[6:0] == 7'h13) begin
                case ($urandom_range(0, 3))
                    0: ri[31:25] = 7'h00;
                    1: ri[31:25] = 7'h20;
                    2: ri[31:25] = 7'h01;
                    default: ;
                endcase
            end
            if ($urandom_range(0, 7) == 0) ri[19:15] = 5'd0;
            run_one(ri, $urandom, $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage sitting directly downstream of the fetch stage in the multi-cycle RV32I core.
- Accepts a raw 32-bit instruction and its PC under the same enabled/completed control handshake used by the other stages.
- Reads both source operands from the register file, decodes fields and the sign-extended immediate, and classifies the instruction.
- Presents registered results to the execute stage with a one-cycle completed pulse.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  asynchronous active-low reset
- enabled  in  1  start request from the controller; sampled only in IDLE
- completed  out  1  one-cycle pulse when decoded outputs are valid
- pc  in  32  PC of the instruction; latched on start
- instr_raw  in  32  instruction word from fetch; latched on start
- rs1_addr  out  5  register-file read address 1; registered
- rs2_addr  out  5  register-file read address 2; registered
- rs1_rdata  in  32  combinational register-file read data 1
- rs2_rdata  in  32  combinational register-file read data 2
- pc_out  out  32  latched PC
- instr_out  out  32  latched instruction
- rd  out  5  destination register
- funct3  out  3  instr[14:12]
- funct7_5  out  1  instr[30]
- rs1_val  out  32  operand 1
- rs2_val  out  32  operand 2
- imm  out  32  sign-extended immediate
- iclass  out  4  instruction class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 MISCMEM, 10 SYSTEM, 11 MULDIV, 15 ILLEGAL
- illegal  out  1  1 when iclass is 15

Behaviour:
- Reset (async, rstn=0): every output goes to 0, including completed, rs1/rs2_addr, pc_out, instr_out, rd, funct3, funct7_5, rs1_val, rs2_val, imm, iclass and illegal. State goes to IDLE.
- Reset asserted mid-operation aborts the operation; no completed pulse is produced.
- FSM has three states: IDLE, READ, DONE.
- IDLE, enabled=1 at edge T:
  - latch instr_raw into instr_out and pc into pc_out
  - drive rs1_addr=instr_raw[19:15] and rs2_addr=instr_raw[24:20]
  - go to READ
- IDLE, enabled=0: hold all outputs; completed=0.
- READ, edge T+1:
  - capture rs1_val and rs2_val; a register address of 0 forces the value to 0 regardless of rdata
  - capture rd, funct3, funct7_5, imm, iclass and illegal from instr_out
  - set completed=1; go to DONE
- DONE, edge T+2: completed=0; go to IDLE.
- Timing: completed is high during cycle T+1..T+2, i.e. two edges after the start. Outputs stay stable until the next start.
- enabled is ignored in READ and DONE. A request held high is accepted again no earlier than the edge after DONE.
- Immediate formats, all sign-extended from instr[31]:
  - I: LOAD, OPIMM, JALR, SYSTEM
  - S: STORE
  - B: BRANCH, with bit0=0
  - U: LUI, AUIPC, low 12 bits = 0
  - J: JAL, with bit0=0
  - OP, MISCMEM: imm=0
- Illegal conditions:
  - instr[1:0] != 2'b11
  - unknown opcode
  - BRANCH with funct3 = 2 or 3
  - LOAD with funct3 = 3, 6 or 7
  - STORE with funct3 > 2
  - OP with funct7 not 0x00 or 0x20, or 0x20 with funct3 not 0 or 5
  - OPIMM shifts (funct3 = 1 or 5) with illegal funct7
  - JALR with funct3 != 0
- When illegal: iclass=15 and illegal=1; rd, funct3, imm and operands are still produced as decoded.

Optional Feature:
- Macro: RV32M_EN.
- Defined: OP with funct7=0x01 gives iclass=11 (MULDIV), illegal=0.
- Undefined: OP with funct7=0x01 gives iclass=15, illegal=1.

Test Plan:
- Reset: rstn=0 mid-READ -> all outputs 0 immediately; no completed pulse; next enabled accepted normally.
- addi x5,x0,-1 (0xFFF00293), pc=0x100, rs1_rdata=0xDEAD -> completed at T+2; iclass=7, rd=5, imm=0xFFFFFFFF, rs1_val=0 (x0 forced), pc_out=0x100.
- sw x2,8(x1) (0x0020A423), rs1_rdata=0x1000, rs2_rdata=0xAB -> iclass=6, rs1_addr=1, rs2_addr=2, imm=8, rs1_val=0x1000, rs2_val=0xAB.
- beq x1,x2,-4 (0xFE208EE3) -> iclass=4, funct3=0, imm=0xFFFFFFFC.
- mul x3,x1,x2 (0x022081B3) -> with RV32M_EN: iclass=11, illegal=0; without it: iclass=15, illegal=1. Also 0x00000000 -> illegal=1.
- enabled held high for 6 cycles -> exactly 2 completed pulses, at T+2 and T+5; enabled toggles during READ are ignored.
